// File: rtl/flag_reg_branch_eval.sv
// Architectural N/V/Z flag register with same-cycle ALU bypass, branch condition
// evaluation with a one-cycle registered result, and a saturating taken-branch counter.
module flag_reg_branch_eval #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_n,
    input  logic [2:0]       flag_we,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_req,
    input  logic [2:0]       br_cond,
    output logic             br_valid,
    output logic             br_taken,
    output logic [2:0]       flags,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [2:0] CC_NEQ    = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GTE    = 3'b100;
    localparam logic [2:0] CC_LTE    = 3'b101;
    localparam logic [2:0] CC_OVFL   = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    // Flag vectors are packed {N,V,Z} throughout.
    function automatic logic eval_cond(input logic [2:0] cond, input logic [2:0] f);
        logic n, v, z;
        n = f[2];
        v = f[1];
        z = f[0];
        case (cond)
            CC_NEQ:    eval_cond = ~z;
            CC_EQ:     eval_cond = z;
            CC_GT:     eval_cond = ~z & ~n;
            CC_LT:     eval_cond = n;
            CC_GTE:    eval_cond = z | (~z & ~n);
            CC_LTE:    eval_cond = n | z;
            CC_OVFL:   eval_cond = v;
            CC_UNCOND: eval_cond = 1'b1;
            default:   eval_cond = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] merge_flags(input logic [2:0] held,
                                               input logic [2:0] fresh,
                                               input logic [2:0] mask);
        merge_flags = (held & ~mask) | (fresh & mask);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        sat_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    logic [2:0]       alu_flags_p0;
    logic [2:0]       wr_mask_p0;
    logic [2:0]       eff_flags_p0;
    logic             accept_p0;
    logic             cond_p0;

    logic [2:0]       flags_p1;
    logic             vld_p1;
    logic             taken_p1;
    logic [CNT_W-1:0] cnt_p1;

    // Stage p0: bypass ALU flags and evaluate the branch in the decode cycle.
    // A flushed op must neither write nor be seen by the branch, so the mask
    // is gated once here and the merged value doubles as the next register state.
    assign alu_flags_p0 = {alu_n, alu_v, alu_z};
    assign wr_mask_p0   = flag_we & {3{~flush}};
    assign eff_flags_p0 = merge_flags(flags_p1, alu_flags_p0, wr_mask_p0);
    assign accept_p0    = br_req & ~stall & ~flush;
    assign cond_p0      = eval_cond(br_cond, eff_flags_p0);

    // Stage p1: registered flags, branch result and taken counter; stall freezes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_p1 <= 3'b000;
            vld_p1   <= 1'b0;
            taken_p1 <= 1'b0;
            cnt_p1   <= '0;
        end else if (!stall) begin
            flags_p1 <= eff_flags_p0;
            vld_p1   <= accept_p0;
            taken_p1 <= accept_p0 & cond_p0;
            if (accept_p0 && cond_p0) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
        end
    end

    assign flags     = flags_p1;
    assign br_valid  = vld_p1;
    assign br_taken  = taken_p1;
    assign taken_cnt = cnt_p1;

endmodule

// File: doc/flag_reg_branch_eval.md
Name: flag_reg_branch_eval

Overview:
- Consumer end of the ALU flag interface: captures the Z/V/N flags produced by the ALU add/sub/logic units into an architectural flag register.
- Evaluates branch condition codes against those flags and resolves branch requests with a registered taken/not-taken result.
- Sits between the EX-stage ALU and the fetch/PC-select logic.
- Keeps a saturating count of taken branches for debug.

Parameters:
- CNT_W, 16, width of the taken-branch counter; saturates at all-ones.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- alu_z  input  1  zero flag from ALU
- alu_v  input  1  overflow flag from ALU
- alu_n  input  1  sign flag from ALU
- flag_we  input  3  per-flag write mask {N,V,Z}; add/sub = 3'b111, XOR/shift = 3'b001, others 3'b000
- stall  input  1  pipeline stall; freezes all state
- flush  input  1  squashes this cycle's flag write and branch request
- br_req  input  1  branch instruction present in decode this cycle
- br_cond  input  3  condition code of the branch
- br_valid  output  1  branch result valid (one-cycle pulse per accepted request)
- br_taken  output  1  branch taken; meaningful only when br_valid=1
- flags  output  3  architectural flags {N,V,Z}
- taken_cnt  output  CNT_W  saturating count of taken branches

Behaviour:
- Reset (rst=1 at edge): flags=3'b000, br_valid=0, br_taken=0, taken_cnt=0. Reset overrides stall and flush.
- Flag register update: each bit whose flag_we bit is 1 loads the matching alu_* bit. Masked-off bits hold.
- Flag writes are suppressed when stall=1 or flush=1.
- Effective flags for evaluation (bypass): per bit, use alu_* if its flag_we bit=1 and flush=0; otherwise use the registered bit. A branch in the same cycle as a flag-setting op therefore sees the new flags with no bubble.
- Condition codes, evaluated on the effective flags:
  - 000 NEQ: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GTE: Z=1 or (Z=0 and N=0)
  - 101 LTE: N=1 or Z=1
  - 110 OVFL: V=1
  - 111 UNCOND: always taken
- Request acceptance: a request is accepted when br_req=1, stall=0 and flush=0.
- Result latency: one cycle. On the edge after acceptance, br_valid=1 and br_taken=evaluated condition.
- Otherwise, on an edge with stall=0: br_valid=0 and br_taken=0.
- stall=1: br_valid, br_taken, flags and taken_cnt all hold their current values. A result already presented stays presented until stall drops; the consumer must not double-count it.
- flush=1 with stall=0: no request accepted, no flag write. br_valid=0 next edge.
- taken_cnt: increments by 1 on each edge that registers br_valid=1 with br_taken=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Unaffected by flush except through the suppressed request.
- Back-to-back requests every cycle are legal. Each produces its own br_valid pulse in the following cycle.
- Undefined flag_we encodings do not exist: any mask is legal and is applied per bit.

Test Plan:
- Reset then idle -> flags=000, br_valid=0, taken_cnt=0. Assert rst for one cycle mid-run with taken_cnt=5 and flags=111 -> all outputs return to 0 on the next edge.
- SUB result zero: flag_we=111, alu_{n,v,z}=0,0,1 with br_req=1, br_cond=001 in the same cycle -> next cycle br_valid=1, br_taken=1 via bypass, flags=001.
- Partial write: flags=110, then XOR with flag_we=001, alu_z=1 -> flags=111. A branch with br_cond=110 -> taken.
- Condition sweep: flags fixed at N=1,V=0,Z=0, br_cond 000..111 on consecutive cycles -> br_taken sequence 1,0,0,1,0,1,0,1. br_valid held high 8 cycles. taken_cnt ends at 4.
- Stall/flush: request accepted, stall=1 for 3 cycles -> br_valid/br_taken held, taken_cnt increments once. br_req=1 with flush=1 and flag_we=111 -> br_valid=0 next cycle, flags unchanged.
- Saturation with CNT_W=4: 17 UNCOND requests -> taken_cnt reaches 15 and stays at 15.
